instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 111 +++++++++++
 tb/tb_instruction_fetch.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: holds the fetch PC, latches memory data into ir, and handles jump redirects and stalls.
// Optional breakpoint/halt support is compiled in with `define FETCH_BREAKPOINT_EN.
module instruction_fetch (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        jump_valid,
  input  logic [7:0]  jump_addr,
  output logic [7:0]  address,
  input  logic [31:0] instruction_in,
  output logic [31:0] ir,
  output logic [7:0]  ir_pc,
  output logic        ir_valid,
  output logic        halted
`ifdef FETCH_BREAKPOINT_EN
  ,
  input  logic        bp_en,
  input  logic [7:0]  bp_addr,
  input  logic        resume
`endif
);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state, state_next;
  logic [7:0]  pc, pc_next;
  logic [31:0] ir_next;
  logic [7:0]  ir_pc_next;
  logic        ir_valid_next;
  logic        bp_hit;

`ifdef FETCH_BREAKPOINT_EN
  // skip suppresses the breakpoint for the single fetch that follows a resume
  logic skip, skip_next;
  assign bp_hit = bp_en && (pc == bp_addr) && !skip;
  assign halted = (state == HALT);
`else
  assign bp_hit = 1'b0;
  assign halted = 1'b0;
`endif

  assign address = pc;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= RUN;
      pc       <= '0;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
`ifdef FETCH_BREAKPOINT_EN
      skip     <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      ir       <= ir_next;
      ir_pc    <= ir_pc_next;
      ir_valid <= ir_valid_next;
`ifdef FETCH_BREAKPOINT_EN
      skip     <= skip_next;
`endif
    end
  end

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    ir_next       = ir;
    ir_pc_next    = ir_pc;
    ir_valid_next = ir_valid;
`ifdef FETCH_BREAKPOINT_EN
    skip_next     = skip;
`endif
    case (state)
      RUN: begin
        // A redirect only counts when the instruction that issued it is valid
        if (jump_valid && ir_valid) begin
          pc_next       = jump_addr;
          ir_valid_next = 1'b0;
        end else if (!stall) begin
          if (bp_hit) begin
            state_next    = HALT;
            ir_valid_next = 1'b0;
          end else begin
            ir_next       = instruction_in;
            ir_pc_next    = pc;
            ir_valid_next = 1'b1;
            pc_next       = pc + 8'd1;
`ifdef FETCH_BREAKPOINT_EN
            skip_next     = 1'b0;
`endif
          end
        end
      end
      HALT: begin
        ir_valid_next = 1'b0;
`ifdef FETCH_BREAKPOINT_EN
        if (resume) begin
          state_next = RUN;
          skip_next  = 1'b1;
        end
`else
        state_next = RUN;
`endif
      end
      default: state_next = RUN;
    endcase
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: a cycle model feeds a scoreboard queue, plus directed checks.
// Breakpoint scenarios are built only when FETCH_BREAKPOINT_EN is defined.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        jump_valid = 1'b0;
  logic [7:0]  jump_addr = '0;
  logic [7:0]  address;
  logic [31:0] instruction_in;
  logic [31:0] ir;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        halted;
  logic        bp_en = 1'b0;
  logic [7:0]  bp_addr = '0;
  logic        resume = 1'b0;

  instruction_fetch dut (
    .clock(clock),
    .reset(reset),
    .stall(stall),
    .jump_valid(jump_valid),
    .jump_addr(jump_addr),
    .address(address),
    .instruction_in(instruction_in),
    .ir(ir),
    .ir_pc(ir_pc),
    .ir_valid(ir_valid),
    .halted(halted)
`ifdef FETCH_BREAKPOINT_EN
    ,
    .bp_en(bp_en),
    .bp_addr(bp_addr),
    .resume(resume)
`endif
  );

  always #5 clock = ~clock;

  // Word 0 is a NOP; other words are distinct per address
  function automatic logic [31:0] mem_word(input logic [7:0] a);
    return (a == 8'd0) ? 32'd0 : {a ^ 8'hC3, ~a, a, 8'h5A};
  endfunction

  assign instruction_in = mem_word(address);

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] ir;
    logic [7:0]  ir_pc;
    logic        valid;
    logic        halted;
  } exp_t;

  exp_t sb[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [7:0]  m_pc = '0;
  logic [31:0] m_ir = '0;
  logic [7:0]  m_ir_pc = '0;
  logic        m_valid = 1'b0;
  logic        m_halt = 1'b0;
  logic        m_skip = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      m_pc = '0; m_ir = '0; m_ir_pc = '0; m_valid = 1'b0; m_halt = 1'b0; m_skip = 1'b0;
    end else if (m_halt) begin
      if (resume) begin
        m_halt = 1'b0;
        m_skip = 1'b1;
      end
    end else if (jump_valid && m_valid) begin
      m_pc = jump_addr;
      m_valid = 1'b0;
    end else if (!stall) begin
      if (bp_en && (m_pc == bp_addr) && !m_skip) begin
        m_halt = 1'b1;
        m_valid = 1'b0;
      end else begin
        m_ir = mem_word(m_pc);
        m_ir_pc = m_pc;
        m_valid = 1'b1;
        m_pc = m_pc + 8'd1;
        m_skip = 1'b0;
      end
    end
  endtask

  task automatic step(input logic r, input logic s, input logic jv, input logic [7:0] ja, input logic res);
    exp_t e, got;
    @(negedge clock);
    reset = r; stall = s; jump_valid = jv; jump_addr = ja; resume = res;
    model_edge();
    e.addr = m_pc; e.ir = m_ir; e.ir_pc = m_ir_pc; e.valid = m_valid; e.halted = m_halt;
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      check("address",  32'(address),  32'(got.addr));
      check("ir",       ir,            got.ir);
      check("ir_pc",    32'(ir_pc),    32'(got.ir_pc));
      check("ir_valid", 32'(ir_valid), 32'(got.valid));
      check("halted",   32'(halted),   32'(got.halted));
    end
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
  endtask

  initial begin
    step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'd9, 1'b1);
    check("rst_address", 32'(address), 32'd0);
    check("rst_ir", ir, 32'd0);
    check("rst_ir_valid", 32'(ir_valid), 32'd0);

    for (int unsigned i = 0; i < 4; i++) begin
      idle(1);
      check("seq_ir_pc", 32'(ir_pc), i);
      check("seq_valid", 32'(ir_valid), 32'd1);
      check("seq_ir", ir, mem_word(8'(i)));
    end

    idle(2);
    check("pre_jump_ir_pc", 32'(ir_pc), 32'd5);
    step(1'b0, 1'b0, 1'b1, 8'd40, 1'b0);
    check("jump_bubble", 32'(ir_valid), 32'd0);
    check("jump_addr", 32'(address), 32'd40);
    check("jump_hold_pc", 32'(ir_pc), 32'd5);
    idle(1);
    check("jump_target", 32'(ir_pc), 32'd40);
    check("jump_target_v", 32'(ir_valid), 32'd1);

    for (int unsigned i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
      check("stall_ir_pc", 32'(ir_pc), 32'd40);
      check("stall_addr", 32'(address), 32'd41);
      check("stall_ir", ir, mem_word(8'd40));
    end
    step(1'b0, 1'b1, 1'b1, 8'd10, 1'b0);
    check("stall_jump", 32'(address), 32'd10);

    step(1'b0, 1'b0, 1'b1, 8'd99, 1'b0);
    check("jump_ignored", 32'(address), 32'd11);
    check("jump_ignored_pc", 32'(ir_pc), 32'd10);

    step(1'b0, 1'b0, 1'b1, 8'd11, 1'b0);
    check("self_jump", 32'(address), 32'd11);
    idle(1);
    check("self_jump_fetch", 32'(ir_pc), 32'd11);

    step(1'b0, 1'b0, 1'b1, 8'd254, 1'b0);
    idle(2);
    check("wrap_255", 32'(ir_pc), 32'd255);
    idle(1);
    check("wrap_0", 32'(ir_pc), 32'd0);
    check("wrap_no_bubble", 32'(ir_valid), 32'd1);

    step(1'b1, 1'b1, 1'b1, 8'd77, 1'b1);
    check("mid_rst_addr", 32'(address), 32'd0);
    check("mid_rst_valid", 32'(ir_valid), 32'd0);
    idle(1);
    check("post_rst_ir_pc", 32'(ir_pc), 32'd0);
    check("post_rst_nop", ir, 32'd0);

`ifdef FETCH_BREAKPOINT_EN
    bp_en = 1'b1;
    bp_addr = 8'd7;
    step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    idle(7);
    check("bp_pre_ir_pc", 32'(ir_pc), 32'd6);
    idle(1);
    check("bp_halted", 32'(halted), 32'd1);
    check("bp_addr_hold", 32'(address), 32'd7);
    check("bp_valid", 32'(ir_valid), 32'd0);
    step(1'b0, 1'b1, 1'b1, 8'd3, 1'b0);
    check("bp_ignore_jump", 32'(address), 32'd7);
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    check("bp_resumed", 32'(halted), 32'd0);
    idle(1);
    check("bp_refetch", 32'(ir_pc), 32'd7);
    check("bp_refetch_v", 32'(ir_valid), 32'd1);
    idle(2);
    check("bp_no_rehalt", 32'(halted), 32'd0);
    bp_addr = 8'(($urandom_range(0, 15)));
`endif

    for (int unsigned i = 0; i < 300; i++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0), 8'(($urandom_range(0, 31))),
           ($urandom_range(0, 2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
